// File: rtl/cond_logic_if.sv
// cond_logic_if: decoder/ALU-side bundle for the condition-and-flags stage.
// Latency: none in the interface itself; strobes are combinational in the stage.
// Backpressure: none; the stage accepts one instruction (or bubble) per cycle.
// Optional feature macro: COND_STATS_EN adds the ExecCount/SkipCount counters.
interface cond_logic_if #(
    parameter int CNT_W = 32
);
    typedef logic [CNT_W-1:0] cnt_t;

    // Upstream instruction/decoder fields
    logic       Valid;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;

    // Gated controls and architectural flags
    logic       CondEx;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic [3:0] Flags;

`ifdef COND_STATS_EN
    cnt_t       ExecCount;
    cnt_t       SkipCount;
`endif

    // Decoder/ALU side drives instruction fields and observes the controls
    modport master (
        output Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        input  CondEx, PCSrc, RegWrite, MemWrite, Flags
`ifdef COND_STATS_EN
        , input ExecCount, SkipCount
`endif
    );

    // Condition stage consumes instruction fields and produces the controls
    modport slave (
        input  Valid, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
        output CondEx, PCSrc, RegWrite, MemWrite, Flags
`ifdef COND_STATS_EN
        , output ExecCount, SkipCount
`endif
    );
endinterface

// File: rtl/cond_logic.sv
// cond_logic: NZCV flag register, condition evaluation and write/branch strobe gating.
// Latency: CondEx/PCSrc/RegWrite/MemWrite combinational; Flags visible one cycle after the write.
// Backpressure: none; Valid=0 is a bubble that freezes all state and drops the strobes.
// Optional feature macro: COND_STATS_EN adds saturating executed/skipped counters.
module cond_logic (
    input  logic         clk,
    input  logic         reset,
    cond_logic_if.slave  bus
);
    // Condition field encodings (Instr[31:28])
    typedef enum logic [3:0] {
        C_EQ = 4'h0, C_NE = 4'h1, C_CS = 4'h2, C_CC = 4'h3,
        C_MI = 4'h4, C_PL = 4'h5, C_VS = 4'h6, C_VC = 4'h7,
        C_HI = 4'h8, C_LS = 4'h9, C_GE = 4'hA, C_LT = 4'hB,
        C_GT = 4'hC, C_LE = 4'hD, C_AL = 4'hE, C_NV = 4'hF
    } cond_e;

    // Architectural flags, bit order {Z,N,C,V} to match ALUFlags
    logic [3:0] r_flags;

    logic       w_z;
    logic       w_n;
    logic       w_c;
    logic       w_v;
    logic       w_cond_ex;
    logic       w_run;
    logic       w_fire;
    cond_e      w_cond;

    assign w_z    = r_flags[3];
    assign w_n    = r_flags[2];
    assign w_c    = r_flags[1];
    assign w_v    = r_flags[0];
    assign w_cond = cond_e'(bus.Cond);

    // Evaluate the condition against the stored flags only; the ALU result of
    // this same instruction must not influence whether it executes.
    always_comb begin
        w_cond_ex = 1'b0;
        unique case (w_cond)
            C_EQ:    w_cond_ex = w_z;
            C_NE:    w_cond_ex = ~w_z;
            C_CS:    w_cond_ex = w_c;
            C_CC:    w_cond_ex = ~w_c;
            C_MI:    w_cond_ex = w_n;
            C_PL:    w_cond_ex = ~w_n;
            C_VS:    w_cond_ex = w_v;
            C_VC:    w_cond_ex = ~w_v;
            C_HI:    w_cond_ex = w_c & ~w_z;
            C_LS:    w_cond_ex = ~w_c | w_z;
            C_GE:    w_cond_ex = (w_n == w_v);
            C_LT:    w_cond_ex = (w_n != w_v);
            C_GT:    w_cond_ex = ~w_z & (w_n == w_v);
            C_LE:    w_cond_ex = w_z | (w_n != w_v);
            C_AL:    w_cond_ex = 1'b1;
            C_NV:    w_cond_ex = 1'b0;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // A real instruction outside reset is eligible to change state; it only
    // does so when its condition also passes.
    assign w_run  = bus.Valid & ~reset;
    assign w_fire = w_run & w_cond_ex;

    // Strobe gating: a failed condition, bubble or reset kills every write
    assign bus.CondEx   = w_cond_ex;
    assign bus.PCSrc    = bus.PCS & w_fire;
    assign bus.RegWrite = bus.RegW & ~bus.NoWrite & w_fire;
    assign bus.MemWrite = bus.MemW & w_fire;
    assign bus.Flags    = r_flags;

    // Flag register: reset wins over any same-cycle write; N/Z and C/V halves
    // are written independently by the two FlagW bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_flags <= 4'b0000;
        end else if (w_fire) begin
            if (bus.FlagW[1]) begin
                r_flags[3:2] <= bus.ALUFlags[3:2];
            end
            if (bus.FlagW[0]) begin
                r_flags[1:0] <= bus.ALUFlags[1:0];
            end
        end
    end

`ifdef COND_STATS_EN
    logic [$bits(bus.ExecCount)-1:0] r_exec_cnt;
    logic [$bits(bus.SkipCount)-1:0] r_skip_cnt;
    logic                            w_skip;

    assign w_skip = w_run & ~w_cond_ex;

    // Saturating executed/skipped counters; bubbles leave both untouched
    always_ff @(posedge clk) begin
        if (reset) begin
            r_exec_cnt <= '0;
            r_skip_cnt <= '0;
        end else begin
            if (w_fire && (r_exec_cnt != '1)) begin
                r_exec_cnt <= r_exec_cnt + 1'b1;
            end
            if (w_skip && (r_skip_cnt != '1)) begin
                r_skip_cnt <= r_skip_cnt + 1'b1;
            end
        end
    end

    assign bus.ExecCount = r_exec_cnt;
    assign bus.SkipCount = r_skip_cnt;
`endif

endmodule

// File: tb/tb_cond_logic.sv
// tb_cond_logic: directed vectors for cond_logic with a queue-based scoreboard.
// Driver applies one vector per cycle just after the rising edge and queues its
// expected outputs; the monitor pops and compares on the following falling edge.
module tb_cond_logic;
    localparam int CNT_W = 4;

    logic clk;
    logic reset;

    cond_logic_if #(.CNT_W(CNT_W)) bus ();

    cond_logic dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        string      nm;
        logic       cx;
        logic       pc;
        logic       rw;
        logic       mw;
        logic [3:0] fl;
        bit         cc;
        int         ec;
        int         sc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %0h, expected %0h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.nm, "CondEx",   {31'd0, bus.CondEx},   {31'd0, e.cx});
                chk(e.nm, "PCSrc",    {31'd0, bus.PCSrc},    {31'd0, e.pc});
                chk(e.nm, "RegWrite", {31'd0, bus.RegWrite}, {31'd0, e.rw});
                chk(e.nm, "MemWrite", {31'd0, bus.MemWrite}, {31'd0, e.mw});
                chk(e.nm, "Flags",    {28'd0, bus.Flags},    {28'd0, e.fl});
`ifdef COND_STATS_EN
                if (e.cc) begin
                    chk(e.nm, "ExecCount", 32'(bus.ExecCount), 32'(e.ec));
                    chk(e.nm, "SkipCount", 32'(bus.SkipCount), 32'(e.sc));
                end
`endif
            end
        end
    end

    // One cycle: ctl = {reset, Valid, PCS, RegW, MemW, NoWrite}; ex = {CondEx, PCSrc, RegWrite, MemWrite}
    task automatic step(input string nm, input logic [5:0] ctl, input logic [3:0] cd,
                        input logic [1:0] fw, input logic [3:0] af,
                        input logic [3:0] ex, input logic [3:0] efl,
                        input bit cc = 1'b0, input int ec = 0, input int sc = 0);
        exp_t e;
        @(posedge clk);
        #1;
        reset        = ctl[5];
        bus.Valid    = ctl[4];
        bus.PCS      = ctl[3];
        bus.RegW     = ctl[2];
        bus.MemW     = ctl[1];
        bus.NoWrite  = ctl[0];
        bus.Cond     = cd;
        bus.FlagW    = fw;
        bus.ALUFlags = af;
        e.nm = nm;
        e.cx = ex[3];
        e.pc = ex[2];
        e.rw = ex[1];
        e.mw = ex[0];
        e.fl = efl;
        e.cc = cc;
        e.ec = ec;
        e.sc = sc;
        q.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset        = 1'b1;
        bus.Valid    = 1'b0;
        bus.PCS      = 1'b0;
        bus.RegW     = 1'b0;
        bus.MemW     = 1'b0;
        bus.NoWrite  = 1'b0;
        bus.Cond     = 4'h0;
        bus.FlagW    = 2'b00;
        bus.ALUFlags = 4'h0;
        repeat (2) @(posedge clk);

        //    name          rst V PCS RW MW NW   Cond   FlagW  ALUF      CX PC RW MW  Flags
        step("rst_hold",    6'b11_1110, 4'hE, 2'b11, 4'b1111, 4'b1000, 4'b0000);
        step("al_regw",     6'b01_0100, 4'hE, 2'b00, 4'b0000, 4'b1010, 4'b0000);
        step("eq_fail",     6'b01_0100, 4'h0, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        step("ne_pass",     6'b01_0000, 4'h1, 2'b00, 4'b0000, 4'b1000, 4'b0000);
        step("ge_pass0",    6'b01_0000, 4'hA, 2'b00, 4'b0000, 4'b1000, 4'b0000);
        step("set_z",       6'b01_0000, 4'hE, 2'b11, 4'b1000, 4'b1000, 4'b0000);
        step("eq_after_z",  6'b01_0000, 4'h0, 2'b00, 4'b0000, 4'b1000, 4'b1000);
        step("ne_after_z",  6'b01_0000, 4'h1, 2'b00, 4'b0000, 4'b0000, 4'b1000);
        step("ls_z",        6'b01_0000, 4'h9, 2'b00, 4'b0000, 4'b1000, 4'b1000);
        step("gt_z",        6'b01_0000, 4'hC, 2'b00, 4'b0000, 4'b0000, 4'b1000);
        step("clr_flags",   6'b01_0000, 4'hE, 2'b11, 4'b0000, 4'b1000, 4'b1000);
        step("fw10",        6'b01_0000, 4'hE, 2'b10, 4'b1111, 4'b1000, 4'b0000);
        step("fw01",        6'b01_0000, 4'hE, 2'b01, 4'b0011, 4'b1000, 4'b1100);
        step("fw00",        6'b01_0000, 4'hE, 2'b00, 4'b0000, 4'b1000, 4'b1111);
        step("set_v",       6'b01_0000, 4'hE, 2'b11, 4'b0001, 4'b1000, 4'b1111);
        step("ge_v",        6'b01_0000, 4'hA, 2'b00, 4'b0000, 4'b0000, 4'b0001);
        step("lt_v",        6'b01_0000, 4'hB, 2'b00, 4'b0000, 4'b1000, 4'b0001);
        step("gt_v",        6'b01_0000, 4'hC, 2'b00, 4'b0000, 4'b0000, 4'b0001);
        step("le_v",        6'b01_0000, 4'hD, 2'b00, 4'b0000, 4'b1000, 4'b0001);
        step("vs_v",        6'b01_0000, 4'h6, 2'b00, 4'b0000, 4'b1000, 4'b0001);
        step("vc_v",        6'b01_0000, 4'h7, 2'b00, 4'b0000, 4'b0000, 4'b0001);
        step("set_c",       6'b01_0000, 4'hE, 2'b11, 4'b0010, 4'b1000, 4'b0001);
        step("hi_c",        6'b01_0000, 4'h8, 2'b00, 4'b0000, 4'b1000, 4'b0010);
        step("ls_c",        6'b01_0000, 4'h9, 2'b00, 4'b0000, 4'b0000, 4'b0010);
        step("cs_c",        6'b01_0000, 4'h2, 2'b00, 4'b0000, 4'b1000, 4'b0010);
        step("cc_c",        6'b01_0000, 4'h3, 2'b00, 4'b0000, 4'b0000, 4'b0010);
        step("mi_c",        6'b01_0000, 4'h4, 2'b00, 4'b0000, 4'b0000, 4'b0010);
        step("pl_c",        6'b01_0000, 4'h5, 2'b00, 4'b0000, 4'b1000, 4'b0010);
        step("nv_block",    6'b01_1110, 4'hF, 2'b11, 4'b1111, 4'b0000, 4'b0010);
        step("eq_fail_blk", 6'b01_1010, 4'h0, 2'b11, 4'b1000, 4'b0000, 4'b0010);
        step("al_pcs_memw", 6'b01_1010, 4'hE, 2'b00, 4'b0000, 4'b1101, 4'b0010);
        step("bubble",      6'b00_0100, 4'hE, 2'b11, 4'b1111, 4'b1000, 4'b0010);
        step("nowrite",     6'b01_0101, 4'hE, 2'b00, 4'b0000, 4'b1000, 4'b0010);
        step("rst_mid",     6'b11_0100, 4'hE, 2'b11, 4'b1101, 4'b1000, 4'b0010);
        step("eq_post_rst", 6'b01_0000, 4'h0, 2'b00, 4'b0000, 4'b0000, 4'b0000);
        step("ne_post_rst", 6'b01_0000, 4'h1, 2'b00, 4'b0000, 4'b1000, 4'b0000);

`ifdef COND_STATS_EN
        step("st_rst",      6'b11_0000, 4'hE, 2'b00, 4'b0000, 4'b1000, 4'b0000);
        for (int k = 0; k < 20; k++) begin
            step("st_exec", 6'b01_0100, 4'hE, 2'b00, 4'b0000, 4'b1010, 4'b0000,
                 1'b1, (k > 15) ? 15 : k, 0);
        end
        for (int k = 0; k < 3; k++) begin
            step("st_skip", 6'b01_0100, 4'hF, 2'b00, 4'b0000, 4'b0000, 4'b0000,
                 1'b1, 15, k);
        end
        step("st_rst_fw",   6'b11_0100, 4'hE, 2'b11, 4'b1111, 4'b1000, 4'b0000, 1'b1, 15, 3);
        step("st_cleared",  6'b00_0100, 4'hE, 2'b00, 4'b0000, 4'b1000, 4'b0000, 1'b1, 0, 0);
        step("st_frozen",   6'b00_0100, 4'h0, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 0);
        step("st_after",    6'b01_0000, 4'hF, 2'b00, 4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 0);
        step("st_skip1",    6'b01_0000, 4'h1, 2'b00, 4'b0000, 4'b1000, 4'b0000, 1'b1, 0, 1);
`endif

        // Bounded drain of the scoreboard
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
